// File: rtl/boot_pkg.sv
// boot_pkg: shared state/error types and the default frame sync byte.
package boot_pkg;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE} boot_state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_CSUM, ERR_LEN, ERR_TIMEOUT} boot_err_e;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/boot_byte_timer.sv
// boot_byte_timer: down-counter reloaded on clear; expire_o fires when it hits zero while enabled.
module boot_byte_timer #(
    parameter int TimeoutCyc = 1_000_000,
    localparam int W = (TimeoutCyc > 2) ? $clog2(TimeoutCyc) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset || clr_i) cnt_q <= W'(TimeoutCyc - 1);
        else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    assign expire_o = en_i && cnt_q == '0;
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: decodes a framed program image from UART bytes into ICCM word writes
// and releases the core from reset once a frame checks out.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int         AddrW      = 12,
    parameter int         TimeoutCyc = 1_000_000,
    parameter logic [7:0] SyncByte   = SYNC_BYTE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_dv_i,
    input  logic [7:0]       rx_byte_i,
    output logic             we_o,
    output logic [AddrW-1:0] addr_o,
    output logic [31:0]      wdata_o,
    output logic             core_reset_o,
    output logic             done_o,
    output logic [1:0]       err_o
);
    localparam logic [16:0] MaxLen = 17'(2 ** AddrW);

    boot_state_e      state_q, state_d;
    boot_err_e        err_q, err_d;
    logic [15:0]      len_q, len_d, len_in;
    logic [1:0]       idx_q, idx_d;
    logic [AddrW-1:0] addr_q, addr_d, waddr_q, waddr_d;
    logic [7:0]       acc_q, acc_d;
    logic [23:0]      wbuf_q, wbuf_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d, core_rst_q, core_rst_d, done_q, done_d;
    logic             active, expire, last_word;

    assign active    = state_q inside {LEN_LO, LEN_HI, DATA, CSUM};
    assign len_in    = {rx_byte_i, len_q[7:0]};
    assign last_word = addr_q == AddrW'(len_q - 16'd1);

    // A byte arriving on the expiry cycle clears the timer and wins.
    boot_byte_timer #(.TimeoutCyc(TimeoutCyc)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (rx_dv_i || !active),
        .en_i    (active && !rx_dv_i),
        .expire_o(expire)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        len_d      = len_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        acc_d      = acc_q;
        wbuf_d     = wbuf_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        if (rx_dv_i) begin
            case (state_q)
                IDLE, DONE: if (rx_byte_i == SyncByte) begin
                    state_d    = LEN_LO;
                    done_d     = 1'b0;
                    err_d      = ERR_NONE;
                    core_rst_d = 1'b1;
                end
                LEN_LO: begin
                    len_d[7:0] = rx_byte_i;
                    state_d    = LEN_HI;
                end
                LEN_HI: begin
                    len_d   = len_in;
                    addr_d  = '0;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ({1'b0, len_in} > MaxLen) ? IDLE : (len_in == '0) ? CSUM : DATA;
                    err_d   = ({1'b0, len_in} > MaxLen) ? ERR_LEN : err_q;
                end
                DATA: begin
                    acc_d  = acc_q ^ rx_byte_i;
                    idx_d  = idx_q + 2'd1;
                    wbuf_d = {rx_byte_i, wbuf_q[23:8]};
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = {rx_byte_i, wbuf_q};
                        addr_d  = addr_q + 1'b1;
                        state_d = last_word ? CSUM : DATA;
                    end
                end
                CSUM: begin
                    state_d    = ((acc_q ^ rx_byte_i) == '0) ? DONE : IDLE;
                    done_d     = (acc_q ^ rx_byte_i) == '0;
                    core_rst_d = (acc_q ^ rx_byte_i) != '0;
                    err_d      = ((acc_q ^ rx_byte_i) == '0) ? ERR_NONE : ERR_CSUM;
                end
                default: ;
            endcase
        end else if (expire) begin
            state_d = IDLE;
            err_d   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            err_q      <= ERR_NONE;
            len_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            acc_q      <= '0;
            wbuf_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            acc_q      <= acc_d;
            wbuf_q     <= wbuf_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
        end
    end

    assign we_o         = we_q;
    assign addr_o       = waddr_q;
    assign wdata_o      = wdata_q;
    assign core_reset_o = core_rst_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames; expected ICCM writes are queued and checked by a monitor.
module tb_uart_boot_loader;
    logic        clk = 1'b0;
    logic        reset, rx_dv;
    logic [7:0]  rx_byte;
    logic        we, core_rst, done;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  err;
    logic [43:0] exp_q[$];
    logic [7:0]  bq[$];
    int          n_checks = 0, n_fail = 0;

    uart_boot_loader #(.AddrW(12), .TimeoutCyc(100), .SyncByte(8'hA5)) dut (
        .clock       (clk),
        .reset       (reset),
        .rx_dv_i     (rx_dv),
        .rx_byte_i   (rx_byte),
        .we_o        (we),
        .addr_o      (addr),
        .wdata_o     (wdata),
        .core_reset_o(core_rst),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {20'd0, addr, wdata}, 64'hDEAD);
            end else begin
                logic [43:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(addr), 64'(e[43:32]));
                chk("write_data", 64'(wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_dv = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic send_q();
        foreach (bq[i]) send(bq[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic status(input string name, input logic d, input logic c, input logic [1:0] e);
        chk({name, "_done"}, 64'(done), 64'(d));
        chk({name, "_core_reset"}, 64'(core_rst), 64'(c));
        chk({name, "_err"}, 64'(err), 64'(e));
    endtask

    task automatic reset_vals(input string name);
        chk({name, "_we"}, 64'(we), 64'd0);
        chk({name, "_addr"}, 64'(addr), 64'd0);
        chk({name, "_wdata"}, 64'(wdata), 64'd0);
        status(name, 1'b0, 1'b1, 2'd0);
    endtask

    initial begin
        logic [7:0] cs;
        reset = 1'b1;
        rx_dv = 1'b0;
        rx_byte = 8'h00;
        idle(3);
        reset = 1'b0;
        reset_vals("reset");

        // good two-word frame
        exp_q.push_back({12'd0, 32'h44332211});
        exp_q.push_back({12'd1, 32'h88776655});
        bq = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        send_q();
        idle(3);
        status("good", 1'b1, 1'b0, 2'd0);

        // bad checksum: writes still happen
        exp_q.push_back({12'd0, 32'h44332211});
        exp_q.push_back({12'd1, 32'h88776655});
        bq[11] = 8'h89;
        send_q();
        idle(3);
        status("csum", 1'b0, 1'b1, 2'd1);

        // length 0x1001 exceeds 4096 words
        bq = '{8'hA5, 8'h01, 8'h10};
        send_q();
        idle(3);
        status("len", 1'b0, 1'b1, 2'd2);
        exp_q.push_back({12'd0, 32'h04030201});
        bq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_q();
        idle(3);
        status("after_len", 1'b1, 1'b0, 2'd0);

        // timeout after two data bytes; later bytes must be ignored in IDLE
        bq = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
        send_q();
        idle(150);
        status("timeout", 1'b0, 1'b1, 2'd3);
        bq = '{8'hCC, 8'hDD, 8'hEE, 8'h11};
        send_q();
        idle(3);
        status("post_timeout", 1'b0, 1'b1, 2'd3);

        // empty image, then garbage
        bq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q();
        idle(3);
        status("empty", 1'b1, 1'b0, 2'd0);
        bq = '{8'h00, 8'hFF};
        send_q();
        idle(3);
        status("garbage", 1'b1, 1'b0, 2'd0);

        // byte arriving on the exact expiry cycle keeps the frame alive
        exp_q.push_back({12'd0, 32'h40302010});
        bq = '{8'hA5, 8'h01, 8'h00, 8'h10};
        send_q();
        idle(99);
        bq = '{8'h20, 8'h30, 8'h40, 8'h40};
        send_q();
        idle(3);
        status("gap99", 1'b1, 1'b0, 2'd0);

        // maximum image: 4096 words, last address 0xFFF
        bq = '{8'hA5, 8'h00, 8'h10};
        cs = 8'h00;
        for (int i = 0; i < 4096; i++) begin
            logic [15:0] w;
            w = 16'(i);
            exp_q.push_back({w[11:0], 16'h0000, w});
            bq.push_back(w[7:0]);
            bq.push_back(w[15:8]);
            bq.push_back(8'h00);
            bq.push_back(8'h00);
            cs = cs ^ w[7:0] ^ w[15:8];
        end
        bq.push_back(cs);
        send_q();
        idle(3);
        status("max", 1'b1, 1'b0, 2'd0);

        // reset pulse coinciding with the second data byte
        bq = '{8'hA5, 8'h01, 8'h00, 8'h11};
        send_q();
        rx_dv = 1'b1;
        rx_byte = 8'h22;
        reset = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0;
        reset = 1'b0;
        reset_vals("midreset");
        exp_q.push_back({12'd0, 32'hEFBEADDE});
        bq = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_q();
        idle(3);
        status("after_reset", 1'b1, 1'b0, 2'd0);

        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
